macguffin_sbox_engine: RTL and testbench
========================================

// Module: macguffin_sbox_engine
// PURPOSE
//  Time-multiplexed MacGuffin S-box layer: evaluates all eight 6->2 S-boxes (S1..S8) on a 48-bit word, LANES lookups per cycle.
//  Sits in the round F-function datapath between key-XOR and output XOR; valid/ready on both sides.
//  Lets area/throughput trade off: LANES=8 is one lookup step, LANES=1 takes eight.
// PARAMETERS
//  LANES     4   S-box lookups per cycle; legal 1,2,4,8 (elaboration $error otherwise)
//  STEPS     8/LANES   localparam, RUN cycles per word
// PORTS
//  clk        in   1   clock, all state on rising edge
//  rst_n      in   1   asynchronous, active-low reset
//  in_valid   in   1   in_data valid
//  in_ready   out  1   engine accepts in_data this cycle
//  in_data    in   48  field k = in_data[6k+5:6k] feeds S(k+1), k=0..7
//  out_valid  out  1   out_data valid
//  out_ready  in   1   consumer takes out_data this cycle
//  out_data   out  16  out_data[2k+1:2k] = S(k+1)(field k)
//  busy       out  1   state != IDLE
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE, step cnt=0, src reg=0, out_data=0, out_valid=0, in_ready=1, busy=0.
//  - FSM IDLE -> RUN -> DONE -> (IDLE | RUN).
//  - Accept = in_valid & in_ready. in_ready = (state==IDLE) | (state==DONE & out_ready).
//  - On accept: latch in_data into src, cnt<=0, state<=RUN; accumulator not cleared (every field overwritten before DONE).
//  - RUN, each cycle: lane j (0..LANES-1) looks up S(cnt*LANES+j+1) on field cnt*LANES+j and writes acc bits [2f+1:2f]; cnt++.
//  - RUN with cnt==STEPS-1: cnt<=0, state<=DONE, out_valid<=1 next cycle.
//  - Latency: out_valid rises STEPS cycles after the accept edge (LANES=8: 1; LANES=1: 8).
//  - DONE: out_valid=1, out_data=acc held stable while !out_ready.
//  - DONE & out_ready & !in_valid: state<=IDLE, out_valid<=0. DONE & out_ready & in_valid: new word accepted same edge, state<=RUN.
//  - Sustained throughput: one word per STEPS+1 cycles.
//  - in_valid while RUN or DONE&!out_ready: ignored (in_ready=0); producer must hold.
//  - out_ready while !out_valid: no effect.
//  - out_data keeps last result after handoff until next DONE; only valid under out_valid.
//  - Reset mid-RUN/DONE: word dropped, no partial result ever asserted.
// STRUCTURE
//  - Package macguffin_pkg: NUM_SBOX=8, SBOX_IN_W=6, SBOX_OUT_W=2.
//  - Package macguffin_pkg: typedef sbox_in_t, sbox_out_t.
//  - Package macguffin_pkg: SBOX_TABLE[8] of logic [0:63][1:0] (S1..S8 contents, single source shared with the standalone S-box modules).
//  - Package macguffin_pkg: typedef enum {IDLE,RUN,DONE} sbox_eng_state_t.
//  - Sub-module macguffin_sbox_lane: combinational; inputs sel [2:0] (S-box index) and 6-bit word, output 2-bit SBOX_TABLE[sel][word].
//  - LANES instances of macguffin_sbox_lane; field select and acc write are indexed by cnt.
// TESTING
//  1. LANES=8, in_data=48'h0, out_ready=1 -> out_valid 1 cycle after accept, out_data=16'hC86E.
//  2. LANES=2, in_data=48'hFFFF_FFFF_FFFF -> out_valid exactly 4 cycles after accept, out_data=16'hEDAF.
//  3. LANES=2/4/8 (LANES=1 in nightly only), all 64 per-field values (field k = i for every k, i=0..63) -> each 2-bit slice matches SBOX_TABLE[k][i]; LANES settings give identical results.
//  4. Backpressure, LANES=4: out_ready=0 for 10 cycles in DONE -> out_data stable, in_ready=0, second in_valid held and accepted on the out_ready edge.
//  5. Back-to-back, LANES=8, in_valid and out_ready always 1 -> one word per 2 cycles, no drop or duplicate vs scoreboard over 1000 random words.
//  6. rst_n low mid-RUN (cnt=1, LANES=2) -> out_valid=0, out_data=0, in_ready=1 after release; next word 48'h0 -> 16'hC86E.

Source files
------------

// File: rtl/macguffin_pkg.sv
// Shared MacGuffin S-box definitions: sizes, lookup types, S1..S8 contents and engine states.
package macguffin_pkg;

    localparam int unsigned NUM_SBOX   = 8;
    localparam int unsigned SBOX_IN_W  = 6;
    localparam int unsigned SBOX_OUT_W = 2;
    localparam int unsigned SBOX_SEL_W = 3;
    localparam int unsigned SBOX_DEPTH = 64;

    typedef logic [SBOX_IN_W-1:0]  sbox_in_t;
    typedef logic [SBOX_OUT_W-1:0] sbox_out_t;
    typedef logic [0:SBOX_DEPTH-1][SBOX_OUT_W-1:0] sbox_table_t;

    // Entry 0 of each table sits in the top two bits of its constant.
    localparam sbox_table_t SBOX_TABLE [NUM_SBOX] = '{
        128'h83D4_2CF9_682B_7D16_36A8_C305_D7BD_424B,
        128'hD1E8_4B72_36C9_A50F_9C63_1EB4_F027_8D5B,
        128'h9A36_E1C5_704B_D82F_6E19_B3A4_05DC_7F8E,
        128'h5C2B_F396_0AE7_148D_B7D0_6A3E_C925_81F6,
        128'h27F4_9BD0_C3A6_5E18_40BE_D712_6FA9_38C5,
        128'hB54E_0D92_7AF1_C638_1D8B_E46F_2C07_93AB,
        128'h1E79_A4C2_F058_3BD6_8C31_5F9A_E647_0DB2,
        128'hE0B7_5C1A_963F_D482_3A6D_07C9_B5E1_4F2B
    };

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } sbox_eng_state_t;

endpackage

// File: rtl/macguffin_sbox_lane.sv
// One S-box lookup lane: selects table S(sel_i+1) and returns its entry for word_i.
module macguffin_sbox_lane
    import macguffin_pkg::*;
(
    input  logic [SBOX_SEL_W-1:0] sel_i,
    input  sbox_in_t              word_i,
    output sbox_out_t             sbox_c_o
);

    assign sbox_c_o = SBOX_TABLE[sel_i][word_i];

endmodule

// File: rtl/macguffin_sbox_engine.sv
// Time-multiplexed MacGuffin S-box layer: LANES lookups per cycle over the eight
// 6->2 S-boxes of a 48-bit word, valid/ready handshake on both sides.
module macguffin_sbox_engine
    import macguffin_pkg::*;
#(
    parameter int unsigned LANES = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [NUM_SBOX*SBOX_IN_W-1:0]   in_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [NUM_SBOX*SBOX_OUT_W-1:0]  out_data,
    output logic                            busy
);

    localparam int unsigned STEPS = NUM_SBOX / LANES;
    localparam int unsigned CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8)) begin : g_bad_lanes
        $error("macguffin_sbox_engine: LANES must be 1, 2, 4 or 8");
    end

    typedef logic [NUM_SBOX-1:0][SBOX_IN_W-1:0]  src_word_t;
    typedef logic [NUM_SBOX-1:0][SBOX_OUT_W-1:0] acc_word_t;

    sbox_eng_state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    src_word_t        src_q, src_d;
    acc_word_t        acc_q, acc_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;

    logic [SBOX_SEL_W-1:0] fidx     [LANES];
    sbox_out_t             lane_out [LANES];

    // Lane j handles field cnt*LANES+j, which is also its S-box index.
    for (genvar j = 0; j < LANES; j++) begin : g_lane
        assign fidx[j] = SBOX_SEL_W'(32'(cnt_q) * LANES + 32'(j));

        macguffin_sbox_lane u_lane (
            .sel_i    (fidx[j]),
            .word_i   (src_q[fidx[j]]),
            .sbox_c_o (lane_out[j])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            src_q       <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            src_q       <= src_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        src_d   = src_q;
        acc_d   = acc_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    src_d   = in_data;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int unsigned j = 0; j < LANES; j++) begin
                    acc_d[fidx[j]] = lane_out[j];
                end
                if (cnt_q == CNT_W'(STEPS - 1)) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                // Handoff and the next accept share the same edge.
                if (out_ready) begin
                    if (in_valid) begin
                        src_d   = in_data;
                        cnt_d   = '0;
                        state_d = RUN;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign out_valid = out_valid_q;
    assign out_data  = acc_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_macguffin_sbox_engine.sv
// Directed bench for macguffin_sbox_engine with LANES=8 (dut0), 4 (dut1) and 2 (dut2).
module tb_macguffin_sbox_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid  [3];
    logic        out_ready [3];
    logic [47:0] in_data   [3];
    logic        in_ready  [3];
    logic        out_valid [3];
    logic        busy      [3];
    logic [15:0] out_data  [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    macguffin_sbox_engine #(.LANES(8)) u_l8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_data(out_data[0]), .busy(busy[0])
    );
    macguffin_sbox_engine #(.LANES(4)) u_l4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_data(out_data[1]), .busy(busy[1])
    );
    macguffin_sbox_engine #(.LANES(2)) u_l2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_data(in_data[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .out_data(out_data[2]), .busy(busy[2])
    );

    // Reference S-box contents, entry 0 in the top two bits.
    function automatic logic [1:0] ref_lut(input int k, input int i);
        logic [127:0] t;
        case (k)
            0:       t = 128'h83D4_2CF9_682B_7D16_36A8_C305_D7BD_424B;
            1:       t = 128'hD1E8_4B72_36C9_A50F_9C63_1EB4_F027_8D5B;
            2:       t = 128'h9A36_E1C5_704B_D82F_6E19_B3A4_05DC_7F8E;
            3:       t = 128'h5C2B_F396_0AE7_148D_B7D0_6A3E_C925_81F6;
            4:       t = 128'h27F4_9BD0_C3A6_5E18_40BE_D712_6FA9_38C5;
            5:       t = 128'hB54E_0D92_7AF1_C638_1D8B_E46F_2C07_93AB;
            6:       t = 128'h1E79_A4C2_F058_3BD6_8C31_5F9A_E647_0DB2;
            default: t = 128'hE0B7_5C1A_963F_D482_3A6D_07C9_B5E1_4F2B;
        endcase
        return t[127-2*i -: 2];
    endfunction

    function automatic logic [15:0] ref_word(input logic [47:0] data);
        logic [15:0] r;
        logic [5:0]  f;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            f = data[6*k +: 6];
            r[2*k +: 2] = ref_lut(k, int'(f));
        end
        return r;
    endfunction

    function automatic logic [47:0] rand48();
        return {16'($urandom), 32'($urandom)};
    endfunction

    function automatic int steps_of(input int d);
        return (d == 0) ? 1 : ((d == 1) ? 2 : 4);
    endfunction

    // Accept one word on dut d, measure edges to out_valid, then hand it off.
    task automatic run_word(input int d, input logic [47:0] data,
                            output logic [15:0] res, output int lat);
        in_valid[d]  = 1'b1;
        in_data[d]   = data;
        out_ready[d] = 1'b1;
        @(posedge clk); #1;
        in_valid[d] = 1'b0;
        lat = 0;
        while (out_valid[d] !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        res = out_data[d];
        @(posedge clk); #1;
        out_ready[d] = 1'b0;
    endtask

    task automatic test_reset();
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (out_valid[d] !== 1'b0) begin
                errors++; $display("FAIL reset_out_valid dut%0d got %b want 0", d, out_valid[d]);
            end
            checks++;
            if (out_data[d] !== 16'h0000) begin
                errors++; $display("FAIL reset_out_data dut%0d got %h want 0000", d, out_data[d]);
            end
            checks++;
            if (in_ready[d] !== 1'b1) begin
                errors++; $display("FAIL reset_in_ready dut%0d got %b want 1", d, in_ready[d]);
            end
            checks++;
            if (busy[d] !== 1'b0) begin
                errors++; $display("FAIL reset_busy dut%0d got %b want 0", d, busy[d]);
            end
        end
    endtask

    task automatic test_zero();
        logic [15:0] res;
        int lat;
        run_word(0, 48'h0, res, lat);
        checks++;
        if (lat !== 1) begin
            errors++; $display("FAIL zero_latency got %0d want 1", lat);
        end
        checks++;
        if (res !== 16'hC86E) begin
            errors++; $display("FAIL zero_data got %h want c86e", res);
        end
        checks++;
        if (out_valid[0] !== 1'b0 || busy[0] !== 1'b0) begin
            errors++; $display("FAIL zero_handoff got valid=%b busy=%b want 0 0", out_valid[0], busy[0]);
        end
    endtask

    task automatic test_ones();
        logic [15:0] res;
        int lat;
        run_word(2, 48'hFFFF_FFFF_FFFF, res, lat);
        checks++;
        if (lat !== 4) begin
            errors++; $display("FAIL ones_latency got %0d want 4", lat);
        end
        checks++;
        if (res !== 16'hEDAF) begin
            errors++; $display("FAIL ones_data got %h want edaf", res);
        end
    endtask

    task automatic test_all_fields();
        logic [15:0] res;
        logic [15:0] exp;
        logic [15:0] by_dut [3];
        int lat;
        for (int i = 0; i < 64; i++) begin
            exp = '0;
            for (int k = 0; k < 8; k++) exp[2*k +: 2] = ref_lut(k, i);
            for (int d = 0; d < 3; d++) begin
                run_word(d, {8{6'(i)}}, res, lat);
                by_dut[d] = res;
                checks++;
                if (res !== exp) begin
                    errors++; $display("FAIL fields_data dut%0d i=%0d got %h want %h", d, i, res, exp);
                end
                checks++;
                if (lat !== steps_of(d)) begin
                    errors++; $display("FAIL fields_latency dut%0d i=%0d got %0d want %0d", d, i, lat, steps_of(d));
                end
            end
            checks++;
            if (by_dut[1] !== by_dut[0] || by_dut[2] !== by_dut[0]) begin
                errors++; $display("FAIL fields_lanes_agree i=%0d got %h %h %h want equal", i, by_dut[0], by_dut[1], by_dut[2]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [47:0] a;
        logic [47:0] b;
        logic [15:0] exp_a;
        logic [15:0] exp_b;
        int lat;
        a = 48'h0123_4567_89AB;
        b = 48'hFEDC_BA98_7654;
        exp_a = ref_word(a);
        exp_b = ref_word(b);
        in_valid[1] = 1'b1; in_data[1] = a; out_ready[1] = 1'b0;
        @(posedge clk); #1;
        in_valid[1] = 1'b0;
        lat = 0;
        while (out_valid[1] !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (lat !== 2) begin
            errors++; $display("FAIL bp_first_latency got %0d want 2", lat);
        end
        in_valid[1] = 1'b1; in_data[1] = b;
        for (int c = 0; c < 10; c++) begin
            #1;
            checks++;
            if (out_valid[1] !== 1'b1 || out_data[1] !== exp_a || in_ready[1] !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cycle=%0d got valid=%b data=%h ready=%b want 1 %h 0",
                         c, out_valid[1], out_data[1], in_ready[1], exp_a);
            end
            @(posedge clk); #1;
        end
        out_ready[1] = 1'b1;
        #1;
        checks++;
        if (in_ready[1] !== 1'b1) begin
            errors++; $display("FAIL bp_release_ready got %b want 1", in_ready[1]);
        end
        @(posedge clk); #1;
        in_valid[1] = 1'b0; out_ready[1] = 1'b0;
        checks++;
        if (out_valid[1] !== 1'b0 || busy[1] !== 1'b1 || out_data[1] !== exp_a) begin
            errors++;
            $display("FAIL bp_second_accept got valid=%b busy=%b data=%h want 0 1 %h",
                     out_valid[1], busy[1], out_data[1], exp_a);
        end
        lat = 0;
        while (out_valid[1] !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (lat !== 2 || out_data[1] !== exp_b) begin
            errors++; $display("FAIL bp_second_word got lat=%0d data=%h want 2 %h", lat, out_data[1], exp_b);
        end
        out_ready[1] = 1'b1;
        @(posedge clk); #1;
        out_ready[1] = 1'b0;
        checks++;
        if (busy[1] !== 1'b0) begin
            errors++; $display("FAIL bp_idle got busy=%b want 0", busy[1]);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] sb [$];
        logic [15:0] exp;
        int  sent = 0;
        int  recv = 0;
        int  cyc = 0;
        int  first_acc = -1;
        int  last_acc = 0;
        bit  acc;
        in_data[0] = rand48(); in_valid[0] = 1'b1; out_ready[0] = 1'b1;
        while (recv < 1000 && cyc < 5000) begin
            if (out_valid[0] === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++; $display("FAIL b2b_extra_output got %h want none", out_data[0]);
                end else begin
                    exp = sb.pop_front();
                    if (out_data[0] !== exp) begin
                        errors++; $display("FAIL b2b_data word=%0d got %h want %h", recv, out_data[0], exp);
                    end
                end
                recv++;
            end
            acc = (in_valid[0] === 1'b1) && (in_ready[0] === 1'b1);
            if (acc) begin
                sb.push_back(ref_word(in_data[0]));
                if (first_acc < 0) first_acc = cyc;
                last_acc = cyc;
                sent++;
            end
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                if (sent < 1000) in_data[0] = rand48();
                else in_valid[0] = 1'b0;
            end
        end
        in_valid[0] = 1'b0; out_ready[0] = 1'b0;
        checks++;
        if (recv !== 1000 || sent !== 1000 || sb.size() !== 0) begin
            errors++; $display("FAIL b2b_count got sent=%0d recv=%0d left=%0d want 1000 1000 0", sent, recv, sb.size());
        end
        checks++;
        if (last_acc - first_acc !== 2 * 999) begin
            errors++; $display("FAIL b2b_throughput got span=%0d want %0d", last_acc - first_acc, 2 * 999);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [15:0] res;
        int lat;
        in_valid[2] = 1'b1; in_data[2] = 48'hFFFF_FFFF_FFFF; out_ready[2] = 1'b1;
        @(posedge clk); #1;
        in_valid[2] = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (busy[2] !== 1'b1 || out_valid[2] !== 1'b0) begin
            errors++; $display("FAIL rst_pre_state got busy=%b valid=%b want 1 0", busy[2], out_valid[2]);
        end
        rst_n = 1'b0;
        #2;
        checks++;
        if (out_valid[2] !== 1'b0 || out_data[2] !== 16'h0 || in_ready[2] !== 1'b1 || busy[2] !== 1'b0) begin
            errors++;
            $display("FAIL rst_async got valid=%b data=%h ready=%b busy=%b want 0 0000 1 0",
                     out_valid[2], out_data[2], in_ready[2], busy[2]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_reset();
        for (int c = 0; c < 6; c++) begin
            checks++;
            if (out_valid[2] !== 1'b0) begin
                errors++; $display("FAIL rst_no_partial cycle=%0d got %b want 0", c, out_valid[2]);
            end
            @(posedge clk); #1;
        end
        out_ready[2] = 1'b0;
        run_word(2, 48'h0, res, lat);
        checks++;
        if (res !== 16'hC86E || lat !== 4) begin
            errors++; $display("FAIL rst_next_word got data=%h lat=%0d want c86e 4", res, lat);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 3; d++) begin
            in_valid[d]  = 1'b0;
            out_ready[d] = 1'b0;
            in_data[d]   = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        test_reset();
        test_zero();
        test_ones();
        test_all_fields();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_run();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
